// File: rtl/csa_128bit_combiner.sv
// Pairs two consecutive W-bit adder beats (low half, then high half) into one
// 2*W-bit result with the low carry folded into the high half.
module csa_128bit_combiner #(
  parameter int unsigned W     = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_sum,
  output logic             out_cout,
  output logic [CNT_W-1:0] res_cnt
);

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [W-1:0]     lo_sum, lo_sum_n;
  logic             lo_c, lo_c_n;
  logic [2*W-1:0]   out_sum_n;
  logic             out_cout_n;
  logic             out_valid_n;
  logic [CNT_W-1:0] res_cnt_n;
  logic [W:0]       inc;
  logic             accept;
  logic             handoff;

  // A held result blocks new beats unless it is handed off this same cycle.
  assign in_ready = (state != S_OUT) || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;
  assign inc      = {1'b0, in_sum} + (W+1)'(lo_c);

  // Next-state and next-register logic.
  always_comb begin
    state_n     = state;
    lo_sum_n    = lo_sum;
    lo_c_n      = lo_c;
    out_sum_n   = out_sum;
    out_cout_n  = out_cout;
    out_valid_n = out_valid;
    res_cnt_n   = res_cnt;
    case (state)
      S_LO: begin
        if (accept) begin
          lo_sum_n = in_sum;
          lo_c_n   = in_cout;
          state_n  = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          out_sum_n   = {inc[W-1:0], lo_sum};
          out_cout_n  = in_cout | inc[W];
          out_valid_n = 1'b1;
          state_n     = S_OUT;
        end
      end
      S_OUT: begin
        if (handoff) begin
          out_valid_n = 1'b0;
          res_cnt_n   = res_cnt + CNT_W'(1);
          state_n     = S_LO;
          // A beat arriving with the handoff is the next low half.
          if (accept) begin
            lo_sum_n = in_sum;
            lo_c_n   = in_cout;
            state_n  = S_HI;
          end
        end
      end
      default: state_n = S_LO;
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LO;
      lo_sum    <= '0;
      lo_c      <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      res_cnt   <= '0;
    end else begin
      state     <= state_n;
      lo_sum    <= lo_sum_n;
      lo_c      <= lo_c_n;
      out_sum   <= out_sum_n;
      out_cout  <= out_cout_n;
      out_valid <= out_valid_n;
      res_cnt   <= res_cnt_n;
    end
  end

endmodule

// File: tb/tb_csa_128bit_combiner.sv
// Scoreboard bench: stimulus side predicts 128-bit results with wide arithmetic,
// a negedge monitor pops and compares on every handoff.
module tb_csa_128bit_combiner;

  localparam int unsigned W        = 64;
  localparam int unsigned TB_CNT_W = 4;
  localparam int          CNT_MAX  = (1 << TB_CNT_W);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_sum;
  logic                in_cout;
  logic                out_valid;
  logic                out_ready;
  logic [2*W-1:0]      out_sum;
  logic                out_cout;
  logic [TB_CNT_W-1:0] res_cnt;

  csa_128bit_combiner #(.W(W), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .res_cnt   (res_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] sum;
    logic         cout;
  } res_t;

  res_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          wraps  = 0;
  bit          m_pend = 1'b0;
  bit          m_have = 1'b0;
  logic [63:0] m_lo   = '0;
  bit          m_loc  = 1'b0;
  int          m_cnt  = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_have = 1'b0;
    m_cnt  = 0;
    q.delete();
  endtask

  // Apply what the DUT saw at the edge that just passed.
  task automatic model_step();
    bit           rdy;
    bit           acc;
    logic [128:0] full;
    res_t         r;
    if (!rst_n) return;
    rdy = !m_pend || out_ready;
    acc = in_valid && rdy;
    if (m_pend && out_ready) begin
      m_pend = 1'b0;
      m_cnt  = (m_cnt + 1) % CNT_MAX;
    end
    if (acc) begin
      if (!m_have) begin
        m_lo   = in_sum;
        m_loc  = in_cout;
        m_have = 1'b1;
      end else begin
        full   = {1'b0, in_sum, m_lo} + {64'b0, m_loc, 64'b0};
        r.sum  = full[127:0];
        r.cout = in_cout | full[128];
        q.push_back(r);
        m_pend = 1'b1;
        m_have = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit iv, input logic [63:0] s, input bit c, input bit ordy);
    in_valid  = iv;
    in_sum    = s;
    in_cout   = c;
    out_ready = ordy;
    @(posedge clk);
    #1;
    model_step();
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // Monitor: state checks every cycle, scoreboard pop on each handoff.
  initial begin
    logic [TB_CNT_W-1:0] prev_cnt;
    res_t                e;
    prev_cnt = '0;
    forever begin
      @(negedge clk);
      chk("out_valid", 128'(out_valid), 128'(m_pend));
      chk("in_ready", 128'(in_ready), 128'(!m_pend || out_ready));
      chk("res_cnt", 128'(res_cnt), 128'(m_cnt));
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 128'(1), 128'(0));
        end else begin
          e = q.pop_front();
          chk("sb_sum", out_sum, e.sum);
          chk("sb_cout", 128'(out_cout), 128'(e.cout));
        end
      end
      if (rst_n && prev_cnt == TB_CNT_W'(CNT_MAX - 1) && res_cnt == '0) wraps++;
      prev_cnt = res_cnt;
    end
  end

  initial begin
    logic [127:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_cout   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_sum", out_sum, 128'(0));
    chk("rst_res_cnt", 128'(res_cnt), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Simple pair.
    cycle(1'b1, 64'h1, 1'b0, 1'b1);
    cycle(1'b1, 64'h2, 1'b0, 1'b0);
    chk("t1_sum", out_sum, 128'h0000000000000002_0000000000000001);
    chk("t1_cout", 128'(out_cout), 128'(0));
    cycle(1'b0, 64'h0, 1'b0, 1'b1);
    chk("t1_cnt", 128'(res_cnt), 128'(1));

    // Low carry into high half.
    cycle(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);
    cycle(1'b1, 64'h5, 1'b0, 1'b0);
    chk("t2_sum", out_sum, 128'h0000000000000006_FFFFFFFFFFFFFFFF);
    chk("t2_cout", 128'(out_cout), 128'(0));
    cycle(1'b0, 64'h0, 1'b0, 1'b1);

    // High half wraps to zero, carry out set.
    cycle(1'b1, 64'h123, 1'b1, 1'b0);
    cycle(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    chk("t3_hi", 128'(out_sum[127:64]), 128'(0));
    chk("t3_lo", 128'(out_sum[63:0]), 128'h123);
    chk("t3_cout", 128'(out_cout), 128'(1));

    // Stall with a pending result, then handoff plus new low beat.
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rnd64(), 1'($urandom_range(0, 1)), 1'b0);
      chk("t4_stable", out_sum, held);
    end
    cycle(1'b1, 64'hAAAA_5555_0000_FFFF, 1'b1, 1'b1);
    cycle(1'b1, 64'h0000_0000_0000_0010, 1'b1, 1'b0);
    chk("t4_sum", out_sum, 128'h0000000000000011_AAAA55550000FFFF);
    chk("t4_cout", 128'(out_cout), 128'(1));
    cycle(1'b0, 64'h0, 1'b0, 1'b1);

    // Reset after a low beat discards it.
    cycle(1'b1, 64'hDEAD, 1'b1, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_valid", 128'(out_valid), 128'(0));
    chk("t5_rst_sum", out_sum, 128'(0));
    chk("t5_rst_cnt", 128'(res_cnt), 128'(0));
    cycle(1'b0, 64'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b1, 64'h7, 1'b0, 1'b0);
    cycle(1'b1, 64'h9, 1'b0, 1'b0);
    chk("t5_sum", out_sum, 128'h0000000000000009_0000000000000007);
    cycle(1'b0, 64'h0, 1'b0, 1'b1);

    // Back-to-back results to wrap the counter.
    for (int i = 0; i < 2 * (CNT_MAX + 2); i++) begin
      cycle(1'b1, rnd64(), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), rnd64(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 6));
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("drain_empty", 128'(q.size()), 128'(0));
    chk("cnt_wrapped", 128'(wraps > 0), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
